// File: rtl/mic_frame_collector_if.sv
// rtl/mic_frame_collector_if.sv - capture/host-read signal bundle for mic_frame_collector
interface mic_frame_collector_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int CHANNELS_WIDTH = 3,
    parameter int FRAME_ADDR     = 7
);
    logic                                   enable;
    logic                                   write_data_mem;
    logic signed [DATA_WIDTH-1:0]           data_in;
    logic                                   rd_en;
    logic [FRAME_ADDR+CHANNELS_WIDTH-1:0]   rd_addr;
    logic signed [DATA_WIDTH-1:0]           rd_data;
    logic                                   rd_valid;
    logic                                   frame_ready;
    logic                                   frame_ack;
    logic                                   rd_bank;
    logic [7:0]                             overrun_count;

    modport master (
        output enable, write_data_mem, data_in, rd_en, rd_addr, frame_ack,
        input  rd_data, rd_valid, frame_ready, rd_bank, overrun_count
    );

    modport slave (
        input  enable, write_data_mem, data_in, rd_en, rd_addr, frame_ack,
        output rd_data, rd_valid, frame_ready, rd_bank, overrun_count
    );
endinterface

// File: rtl/mic_frame_collector.sv
// rtl/mic_frame_collector.sv - ping-pong frame buffer for per-channel FIR results with host handoff
module mic_frame_collector #(
    parameter int DATA_WIDTH     = 16,
    parameter int CHANNELS       = 8,
    parameter int CHANNELS_WIDTH = 3,
    parameter int FRAME_SAMPLES  = 128,
    parameter int FRAME_ADDR     = 7
) (
    input  logic                 clk,
    input  logic                 resetn,
    mic_frame_collector_if.slave bus
);
    localparam int DEPTH = 2 * FRAME_SAMPLES * CHANNELS;
    localparam int AW    = 1 + FRAME_ADDR + CHANNELS_WIDTH;

    typedef enum logic {S_EMPTY, S_PENDING} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_wr_bank;
    logic                    w_wr_bank_next;
    logic                    w_overrun;
    logic [CHANNELS_WIDTH-1:0] r_wr_chan;
    logic [FRAME_ADDR-1:0]   r_wr_sample;
    logic [7:0]              r_overrun_count;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_write;
    logic                    w_last_chan;
    logic                    w_last_sample;
    logic                    w_frame_done;
    logic [AW-1:0]           w_wr_addr;
    logic [AW-1:0]           w_rd_addr;

    assign w_write       = bus.write_data_mem && bus.enable;
    assign w_last_chan   = (r_wr_chan == CHANNELS_WIDTH'(CHANNELS - 1));
    assign w_last_sample = (r_wr_sample == FRAME_ADDR'(FRAME_SAMPLES - 1));
    assign w_frame_done  = w_write && w_last_chan && w_last_sample;
    assign w_wr_addr     = {r_wr_bank, r_wr_sample, r_wr_chan};
    assign w_rd_addr     = {~r_wr_bank, bus.rd_addr};

    // Dropping enable discards any partial frame by rewinding the write position.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_chan   <= '0;
            r_wr_sample <= '0;
        end else if (!bus.enable) begin
            r_wr_chan   <= '0;
            r_wr_sample <= '0;
        end else if (w_write) begin
            if (w_last_chan) begin
                r_wr_chan   <= '0;
                r_wr_sample <= w_last_sample ? '0 : r_wr_sample + 1'b1;
            end else begin
                r_wr_chan   <= r_wr_chan + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[w_wr_addr] <= bus.data_in;
        end
    end

    // An ack arriving with a new frame_done frees the host bank first, so the new frame swaps in.
    always_comb begin
        w_state_next   = r_state;
        w_wr_bank_next = r_wr_bank;
        w_overrun      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_frame_done) begin
                    w_state_next   = S_PENDING;
                    w_wr_bank_next = ~r_wr_bank;
                end
            end
            S_PENDING: begin
                if (bus.frame_ack && w_frame_done) begin
                    w_wr_bank_next = ~r_wr_bank;
                end else if (bus.frame_ack) begin
                    w_state_next = S_EMPTY;
                end else if (w_frame_done) begin
                    w_overrun = 1'b1;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_EMPTY;
            r_wr_bank       <= 1'b0;
            r_overrun_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_wr_bank <= w_wr_bank_next;
            if (w_overrun && r_overrun_count != 8'hFF) begin
                r_overrun_count <= r_overrun_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= r_mem[w_rd_addr];
            end
        end
    end

    assign bus.rd_data       = r_rd_data;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.frame_ready   = (r_state == S_PENDING);
    assign bus.rd_bank       = ~r_wr_bank;
    assign bus.overrun_count = r_overrun_count;
endmodule

// File: tb/tb_mic_frame_collector.sv
// tb/tb_mic_frame_collector.sv - randomized directed bench for mic_frame_collector against a frame-level model
module tb_mic_frame_collector;
    localparam int FRAME_WORDS = 1024;

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    mic_frame_collector_if #(.DATA_WIDTH(16), .CHANNELS_WIDTH(3), .FRAME_ADDR(7)) bus ();

    mic_frame_collector #(
        .DATA_WIDTH(16), .CHANNELS(8), .CHANNELS_WIDTH(3), .FRAME_SAMPLES(128), .FRAME_ADDR(7)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model: a flat word position per frame plus a pending flag.
    logic [15:0] ref_mem [2][FRAME_WORDS];
    int          m_pos;
    bit          m_bank;
    bit          m_pending;
    int          m_ovr;
    logic [15:0] m_rd_data;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_bank = 1'b0;
        m_pending = 1'b0;
        m_ovr = 0;
        m_rd_data = '0;
    endtask

    task automatic step(input logic s, input logic [15:0] d, input logic ack, input logic en);
        bit done;
        bus.write_data_mem = s;
        bus.data_in        = d;
        bus.frame_ack      = ack;
        bus.enable         = en;
        @(posedge clk);
        done = 1'b0;
        if (!en) begin
            m_pos = 0;
        end else if (s) begin
            ref_mem[m_bank][m_pos] = d;
            if (m_pos == FRAME_WORDS - 1) begin
                m_pos = 0;
                done  = 1'b1;
            end else begin
                m_pos++;
            end
        end
        if (ack && m_pending) m_pending = 1'b0;
        if (done) begin
            if (!m_pending) begin
                m_pending = 1'b1;
                m_bank    = ~m_bank;
            end else if (m_ovr < 255) begin
                m_ovr++;
            end
        end
        #1;
        bus.write_data_mem = 1'b0;
        bus.frame_ack      = 1'b0;
    endtask

    // mode 0: data=idx, mode 1: data=1000+idx, mode 2: random; random idle gaps between strobes
    task automatic send_strobes(input int n, input int mode, input logic ack_last,
                                output logic [15:0] first_d);
        logic [15:0] d;
        first_d = '0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 16'($urandom), 1'b0, 1'b1);
            case (mode)
                0:       d = 16'(i);
                1:       d = 16'(1000 + i);
                default: d = 16'($urandom);
            endcase
            if (i == 0) first_d = d;
            step(1'b1, d, ack_last && (i == n - 1), 1'b1);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".frame_ready"}, 16'(bus.frame_ready), 16'(m_pending));
        chk({tag, ".rd_bank"}, 16'(bus.rd_bank), 16'(!m_bank));
        chk({tag, ".overrun"}, 16'(bus.overrun_count), 16'(m_ovr));
    endtask

    task automatic do_read(input string tag, input logic [9:0] addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        step(1'b0, '0, 1'b0, 1'b1);
        m_rd_data = ref_mem[!m_bank][addr];
        chk({tag, ".rd_valid"}, 16'(bus.rd_valid), 16'd1);
        chk({tag, ".rd_data"}, $unsigned(bus.rd_data), m_rd_data);
        bus.rd_en = 1'b0;
        step(1'b0, '0, 1'b0, 1'b1);
        chk({tag, ".rd_valid_low"}, 16'(bus.rd_valid), 16'd0);
        chk({tag, ".rd_hold"}, $unsigned(bus.rd_data), m_rd_data);
    endtask

    task automatic random_reads(input string tag, input int n);
        for (int i = 0; i < n; i++) do_read(tag, 10'($urandom_range(0, FRAME_WORDS - 1)));
    endtask

    initial begin
        logic [15:0] first_d;
        logic [15:0] exp_c;
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        bus.enable = 1'b0;
        bus.write_data_mem = 1'b0;
        bus.data_in = '0;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;
        bus.frame_ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        chk("reset.rd_data", $unsigned(bus.rd_data), 16'd0);
        chk("reset.rd_valid", 16'(bus.rd_valid), 16'd0);
        chk("reset.frame_ready", 16'(bus.frame_ready), 16'd0);
        chk("reset.overrun", 16'(bus.overrun_count), 16'd0);
        chk("reset.rd_bank", 16'(bus.rd_bank), 16'd1);

        // T1: ramp frame
        send_strobes(FRAME_WORDS - 1, 0, 1'b0, first_d);
        chk("t1.not_ready_yet", 16'(bus.frame_ready), 16'd0);
        step(1'b1, 16'(FRAME_WORDS - 1), 1'b0, 1'b1);
        chk("t1.frame_ready", 16'(bus.frame_ready), 16'd1);
        chk("t1.rd_bank", 16'(bus.rd_bank), 16'd0);
        chk_state("t1");
        do_read("t1.addr_5_3", {7'd5, 3'd3});
        exp_c = 16'd43;
        chk("t1.value43", $unsigned(bus.rd_data), exp_c);
        random_reads("t1", 4);

        // T2: ack, ack again in EMPTY (ignored), second frame
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t2.ack_clears", 16'(bus.frame_ready), 16'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk_state("t2.ack_empty");
        send_strobes(FRAME_WORDS, 1, 1'b0, first_d);
        chk("t2.frame_ready", 16'(bus.frame_ready), 16'd1);
        chk("t2.rd_bank", 16'(bus.rd_bank), 16'd1);
        do_read("t2.addr0", 10'd0);
        exp_c = 16'd1000;
        chk("t2.value1000", $unsigned(bus.rd_data), exp_c);

        // T3: two frames without ack -> one overrun, first frame intact
        step(1'b0, '0, 1'b1, 1'b1);
        send_strobes(FRAME_WORDS, 2, 1'b0, first_d);
        exp_c = first_d;
        send_strobes(FRAME_WORDS, 2, 1'b0, first_d);
        chk("t3.overrun", 16'(bus.overrun_count), 16'd1);
        chk("t3.frame_ready", 16'(bus.frame_ready), 16'd1);
        chk("t3.rd_bank", 16'(bus.rd_bank), 16'd0);
        do_read("t3.addr0", 10'd0);
        chk("t3.first_frame", $unsigned(bus.rd_data), exp_c);
        random_reads("t3", 4);

        // T4: ack coincident with frame_done while pending
        send_strobes(FRAME_WORDS, 2, 1'b1, first_d);
        chk("t4.overrun", 16'(bus.overrun_count), 16'd1);
        chk("t4.frame_ready", 16'(bus.frame_ready), 16'd1);
        chk("t4.rd_bank", 16'(bus.rd_bank), 16'd1);
        chk_state("t4");
        random_reads("t4", 4);

        // T5: partial frame dropped by a one-cycle enable drop
        step(1'b0, '0, 1'b1, 1'b1);
        send_strobes(300, 2, 1'b0, first_d);
        step(1'b1, 16'($urandom), 1'b0, 1'b0);
        send_strobes(FRAME_WORDS - 1, 2, 1'b0, first_d);
        exp_c = first_d;
        chk("t5.not_ready_yet", 16'(bus.frame_ready), 16'd0);
        step(1'b1, 16'($urandom), 1'b0, 1'b1);
        chk("t5.frame_ready", 16'(bus.frame_ready), 16'd1);
        chk_state("t5");
        do_read("t5.addr0", 10'd0);
        chk("t5.strobe301", $unsigned(bus.rd_data), exp_c);
        random_reads("t5", 3);

        // T6: async reset mid-frame while a frame is pending and overrun is nonzero
        send_strobes(500, 2, 1'b0, first_d);
        resetn = 1'b0;
        #2;
        model_reset();
        chk("t6.rd_data", $unsigned(bus.rd_data), 16'd0);
        chk("t6.rd_valid", 16'(bus.rd_valid), 16'd0);
        chk("t6.frame_ready", 16'(bus.frame_ready), 16'd0);
        chk("t6.overrun", 16'(bus.overrun_count), 16'd0);
        chk("t6.rd_bank", 16'(bus.rd_bank), 16'd1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        send_strobes(FRAME_WORDS - 1, 2, 1'b0, first_d);
        chk("t6.not_ready_yet", 16'(bus.frame_ready), 16'd0);
        step(1'b1, 16'($urandom), 1'b0, 1'b1);
        chk("t6.frame_ready", 16'(bus.frame_ready), 16'd1);
        chk("t6.rd_bank_after", 16'(bus.rd_bank), 16'd0);
        chk_state("t6");
        do_read("t6.addr0", 10'd0);
        chk("t6.clean_frame", $unsigned(bus.rd_data), first_d);
        random_reads("t6", 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
